// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands an LM/SM register mask into one register/memory
// micro-op per selected register, stalling the front of the pipeline meanwhile.
// Optional feature: LMSM_ISA_BITORDER_EN -- when defined, mask bit 7 selects R0
// and bit 0 selects R7; otherwise mask bit i selects Ri. Transfer order is
// always ascending register index.
module lmsm_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [7:0]        reg_mask,
  input  logic              hold,
  output logic              stall,
  output logic              uop_valid,
  output logic [REG_AW-1:0] uop_reg,
  output logic [DATA_W-1:0] uop_mem_addr,
  output logic              reg_wr_en,
  output logic              mem_wr_en,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  logic [1:0]        state_q;
  logic [7:0]        mask_q;
  logic [DATA_W-1:0] base_q;
  logic [3:0]        cnt_q;
  logic              is_load_q;

  logic [7:0]        mask_map;
  logic [REG_AW-1:0] pick;
  logic [7:0]        mask_nxt;
  logic              accept;
  logic              in_xfer;
  logic              advance;

  // Map the instruction mask onto register indices (bit r => register r).
`ifdef LMSM_ISA_BITORDER_EN
  always_comb begin
    mask_map = '0;
    for (int i = 0; i < 8; i++) mask_map[i] = reg_mask[7-i];
  end
`else
  always_comb begin
    mask_map = reg_mask;
  end
`endif

  // Lowest-index pending register; scan high to low so the lowest set bit wins.
  always_comb begin
    pick = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) pick = REG_AW'(i);
    end
  end

  assign mask_nxt = mask_q & ~(8'd1 << pick);
  assign accept   = (state_q == IDLE) && start && ((opcode == OP_LM) || (opcode == OP_SM));
  assign in_xfer  = (state_q == XFER);
  assign advance  = in_xfer && !hold;

  // Sequencer state: accept in IDLE, retire one micro-op per unheld XFER cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mask_q    <= mask_map;
          base_q    <= base_addr;
          cnt_q     <= '0;
          is_load_q <= (opcode == OP_LM);
          state_q   <= (mask_map == 8'd0) ? DONE : XFER;
        end
        XFER: if (!hold) begin
          mask_q <= mask_nxt;
          cnt_q  <= cnt_q + 4'd1;
          if (mask_nxt == 8'd0) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Micro-op outputs come only from registered state; zero outside XFER.
  always_comb begin
    stall        = (state_q != IDLE) || accept;
    uop_valid    = in_xfer;
    uop_reg      = in_xfer ? pick : '0;
    uop_mem_addr = in_xfer ? (base_q + DATA_W'(cnt_q)) : '0;
    reg_wr_en    = advance && is_load_q;
    mem_wr_en    = advance && !is_load_q;
    done         = (state_q == DONE);
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed vectors with hand-computed expectations for
// lmsm_sequencer. Expected register indices follow LMSM_ISA_BITORDER_EN.
module tb_lmsm_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        hold;
  logic        stall, uop_valid, reg_wr_en, mem_wr_en, done;
  logic [2:0]  uop_reg;
  logic [15:0] uop_mem_addr;

  int errors = 0;
  int checks = 0;

`ifdef LMSM_ISA_BITORDER_EN
  localparam logic [2:0] T1A = 3'd5, T1B = 3'd7, T3A = 3'd6, T3B = 3'd7;
  localparam logic [2:0] T5R = 3'd7, T6A = 3'd0, T6B = 3'd7;
`else
  localparam logic [2:0] T1A = 3'd0, T1B = 3'd2, T3A = 3'd0, T3B = 3'd1;
  localparam logic [2:0] T5R = 3'd0, T6A = 3'd7, T6B = 3'd0;
`endif

  lmsm_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .base_addr(base_addr), .reg_mask(reg_mask), .hold(hold),
    .stall(stall), .uop_valid(uop_valid), .uop_reg(uop_reg),
    .uop_mem_addr(uop_mem_addr), .reg_wr_en(reg_wr_en),
    .mem_wr_en(mem_wr_en), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic s, input logic v, input logic [2:0] r,
                      input logic [15:0] a, input logic rw, input logic mw, input logic d);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".valid"}, 32'(uop_valid), 32'(v));
    chk({tag, ".reg"},   32'(uop_reg), 32'(r));
    chk({tag, ".addr"},  32'(uop_mem_addr), 32'(a));
    chk({tag, ".rwe"},   32'(reg_wr_en), 32'(rw));
    chk({tag, ".mwe"},   32'(mem_wr_en), 32'(mw));
    chk({tag, ".done"},  32'(done), 32'(d));
  endtask

  // Check at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic s, input logic v, input logic [2:0] r,
                     input logic [15:0] a, input logic rw, input logic mw, input logic d);
    @(negedge clk);
    outs(tag, s, v, r, a, rw, mw, d);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] op, input logic [15:0] b, input logic [7:0] m);
    start = 1'b1; opcode = op; base_addr = b; reg_mask = m;
  endtask

  task automatic idle_in;
    start = 1'b0; opcode = 4'h0; base_addr = 16'hDEAD; reg_mask = 8'hA5;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = 4'h0; base_addr = '0; reg_mask = '0; hold = 1'b0;
    #3;
    outs("reset", 0, 0, 3'd0, 16'h0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // LM base 0x0040 mask 0x05
    go(4'b0110, 16'h0040, 8'h05);
    cyc("lm.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("lm.c1", 1, 1, T1A, 16'h0040, 1, 0, 0);
    cyc("lm.c2", 1, 1, T1B, 16'h0041, 1, 0, 0);
    cyc("lm.c3", 1, 0, 3'd0, 16'h0, 0, 0, 1);
    cyc("lm.c4", 0, 0, 3'd0, 16'h0, 0, 0, 0);

    // SM base 0xFFFF mask 0xFF, address wrap
    go(4'b0111, 16'hFFFF, 8'hFF);
    cyc("sm.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    for (int i = 0; i < 8; i++) cyc($sformatf("sm.c%0d", i + 1), 1, 1, 3'(i), 16'(16'hFFFF + i), 0, 1, 0);
    cyc("sm.c9", 1, 0, 3'd0, 16'h0, 0, 0, 1);
    cyc("sm.c10", 0, 0, 3'd0, 16'h0, 0, 0, 0);

    // SM mask 0x03 with hold in cycle 1; start during XFER must be ignored
    go(4'b0111, 16'h0100, 8'h03);
    cyc("hold.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in(); hold = 1'b1;
    cyc("hold.c1", 1, 1, T3A, 16'h0100, 0, 0, 0);
    hold = 1'b0; go(4'b0110, 16'h7777, 8'hF0);
    cyc("hold.c2", 1, 1, T3A, 16'h0100, 0, 1, 0);
    idle_in();
    cyc("hold.c3", 1, 1, T3B, 16'h0101, 0, 1, 0);
    cyc("hold.c4", 1, 0, 3'd0, 16'h0, 0, 0, 1);
    cyc("hold.c5", 0, 0, 3'd0, 16'h0, 0, 0, 0);

    // Zero mask LM, then non-LM/SM opcode
    go(4'b0110, 16'h1234, 8'h00);
    cyc("zero.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("zero.c1", 1, 0, 3'd0, 16'h0, 0, 0, 1);
    cyc("zero.c2", 0, 0, 3'd0, 16'h0, 0, 0, 0);
    go(4'b0001, 16'h1234, 8'hFF);
    cyc("badop.c0", 0, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("badop.c1", 0, 0, 3'd0, 16'h0, 0, 0, 0);

    // Reset mid-XFER, then a fresh SM
    go(4'b0110, 16'h0010, 8'hFF);
    cyc("mid.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("mid.c1", 1, 1, 3'd0, 16'h0010, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1 outs("mid.rst", 0, 0, 3'd0, 16'h0, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    go(4'b0111, 16'h0020, 8'h01);
    cyc("post.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("post.c1", 1, 1, T5R, 16'h0020, 0, 1, 0);
    cyc("post.c2", 1, 0, 3'd0, 16'h0, 0, 0, 1);

    // Single-bit masks at both ends of the mask
    go(4'b0110, 16'h0000, 8'h80);
    cyc("m80.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("m80.c1", 1, 1, T6A, 16'h0000, 1, 0, 0);
    cyc("m80.c2", 1, 0, 3'd0, 16'h0, 0, 0, 1);
    go(4'b0110, 16'h0005, 8'h01);
    cyc("m01.c0", 1, 0, 3'd0, 16'h0, 0, 0, 0);
    idle_in();
    cyc("m01.c1", 1, 1, T6B, 16'h0005, 1, 0, 0);
    cyc("m01.c2", 1, 0, 3'd0, 16'h0, 0, 0, 1);
    cyc("m01.c3", 0, 0, 3'd0, 16'h0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
